// File: rtl/huff_dec_if.sv
// Table-config, block-input and symbol-output bundle for huff_decoder.
interface huff_dec_if #(
    parameter int unsigned SYMBOL_WIDTH      = 4,
    parameter int unsigned ENC_MAX_WIDTH     = 4,
    parameter int unsigned ENC_MAX_LEN_WIDTH = 3,
    parameter int unsigned OUTPUT_BLOCK_SIZE = 8,
    parameter int unsigned NUM_SYMBOLS       = 16
) ();
    localparam int unsigned NBITS_W = $clog2(OUTPUT_BLOCK_SIZE) + 1;

    logic                         config_en;
    logic [ENC_MAX_WIDTH-1:0]     config_enc;
    logic [ENC_MAX_LEN_WIDTH-1:0] config_enc_len;
    logic [NUM_SYMBOLS-1:0]       config_select;
    logic [OUTPUT_BLOCK_SIZE-1:0] in_block;
    logic                         in_valid;
    logic                         in_last;
    logic [NBITS_W-1:0]           in_nbits;
    logic                         in_ready;
    logic [SYMBOL_WIDTH-1:0]      sym_out;
    logic                         sym_valid;
    logic                         sym_ready;
    logic                         done;
    logic                         error;

    modport master (
        output config_en, config_enc, config_enc_len, config_select,
        output in_block, in_valid, in_last, in_nbits, sym_ready,
        input  in_ready, sym_out, sym_valid, done, error
    );

    modport slave (
        input  config_en, config_enc, config_enc_len, config_select,
        input  in_block, in_valid, in_last, in_nbits, sym_ready,
        output in_ready, sym_out, sym_valid, done, error
    );
endinterface

// File: rtl/huff_decoder.sv
// Streaming LSB-first Huffman decoder: block bit buffer, parallel table match,
// one symbol per cycle over valid/ready.
module huff_decoder #(
    parameter int unsigned SYMBOL_WIDTH      = 4,
    parameter int unsigned ENC_MAX_WIDTH     = 4,
    parameter int unsigned ENC_MAX_LEN_WIDTH = 3,
    parameter int unsigned OUTPUT_BLOCK_SIZE = 8,
    parameter int unsigned NUM_SYMBOLS       = 16
) (
    input  logic      clk,
    input  logic      rst,
    huff_dec_if.slave bus
);
    localparam int unsigned BUF_W   = 2 * OUTPUT_BLOCK_SIZE;
    localparam int unsigned FILL_W  = $clog2(BUF_W + 1);
    localparam int unsigned NBITS_W = $clog2(OUTPUT_BLOCK_SIZE) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_ERR} state_e;

    state_e                       state_q, state_d;
    logic [BUF_W-1:0]             bits_q, bits_d;
    logic [FILL_W-1:0]            fill_q, fill_d;
    logic                         last_seen_q, last_seen_d;
    logic [SYMBOL_WIDTH-1:0]      sym_out_q, sym_out_d;
    logic                         sym_valid_q, sym_valid_d;
    logic                         done_q, done_d;
    logic                         error_q, error_d;
    logic [ENC_MAX_WIDTH-1:0]     enc_q [NUM_SYMBOLS];
    logic [ENC_MAX_WIDTH-1:0]     enc_d [NUM_SYMBOLS];
    logic [ENC_MAX_LEN_WIDTH-1:0] len_q [NUM_SYMBOLS];
    logic [ENC_MAX_LEN_WIDTH-1:0] len_d [NUM_SYMBOLS];

    logic                         hit;
    logic [SYMBOL_WIDTH-1:0]      hit_idx;
    logic [ENC_MAX_LEN_WIDTH-1:0] hit_len;
    logic                         in_ready_c;
    logic                         accept, fire, done_c, err_set;
    logic [NBITS_W-1:0]           add_bits;
    logic [OUTPUT_BLOCK_SIZE-1:0] blk_mask;
    logic [ENC_MAX_LEN_WIDTH-1:0] use_len;
    logic [FILL_W-1:0]            fill_after;

    function automatic logic [ENC_MAX_WIDTH-1:0] code_mask(input logic [ENC_MAX_LEN_WIDTH-1:0] len);
        logic [ENC_MAX_WIDTH-1:0] m;
        for (int b = 0; b < ENC_MAX_WIDTH; b++) m[b] = (ENC_MAX_LEN_WIDTH'(b) < len);
        return m;
    endfunction

    // Parallel table match; scanning downward leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_len = '0;
        for (int i = int'(NUM_SYMBOLS) - 1; i >= 0; i--) begin
            if (len_q[i] != '0 && FILL_W'(len_q[i]) <= fill_q &&
                ((bits_q[ENC_MAX_WIDTH-1:0] ^ enc_q[i]) & code_mask(len_q[i])) == '0) begin
                hit     = 1'b1;
                hit_idx = SYMBOL_WIDTH'(i);
                hit_len = len_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bits_d      = bits_q;
        fill_d      = fill_q;
        last_seen_d = last_seen_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = sym_valid_q;
        done_d      = 1'b0;
        error_d     = error_q;
        enc_d       = enc_q;
        len_d       = len_q;

        in_ready_c = !rst && !error_q && !last_seen_q &&
                     (fill_q <= FILL_W'(BUF_W - OUTPUT_BLOCK_SIZE));
        accept     = bus.in_valid && in_ready_c;
        fire       = hit && (!sym_valid_q || bus.sym_ready) && !bus.config_en && !error_q;
        done_c     = last_seen_q && (fill_q == '0) && !sym_valid_q;
        err_set    = !hit && ((fill_q >= FILL_W'(ENC_MAX_WIDTH)) ||
                              (last_seen_q && fill_q != '0));

        // A short tail block contributes only its in_nbits valid bits.
        add_bits = NBITS_W'(OUTPUT_BLOCK_SIZE);
        if (bus.in_last && bus.in_nbits != '0 && bus.in_nbits < NBITS_W'(OUTPUT_BLOCK_SIZE))
            add_bits = bus.in_nbits;
        for (int b = 0; b < OUTPUT_BLOCK_SIZE; b++) blk_mask[b] = (NBITS_W'(b) < add_bits);

        use_len    = fire ? hit_len : '0;
        fill_after = fill_q - FILL_W'(use_len);
        bits_d     = bits_q >> use_len;
        fill_d     = fill_after;

        if (accept) begin
            bits_d = bits_d | (BUF_W'(bus.in_block & blk_mask) << fill_after);
            fill_d = fill_after + FILL_W'(add_bits);
            if (bus.in_last) last_seen_d = 1'b1;
        end
        if (done_c) last_seen_d = 1'b0;
        done_d = done_c;

        if (fire) begin
            sym_out_d   = hit_idx;
            sym_valid_d = 1'b1;
        end else if (sym_valid_q && bus.sym_ready) begin
            sym_valid_d = 1'b0;
        end

        if (err_set) error_d = 1'b1;

        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (bus.config_en && bus.config_select[i]) begin
                enc_d[i] = bus.config_enc;
                len_d[i] = bus.config_enc_len;
            end
        end

        case (state_q)
            ST_IDLE:  if (accept) state_d = bus.in_last ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (accept && bus.in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (done_c) state_d = ST_IDLE;
            default:  state_d = state_q;
        endcase
        if (err_set) state_d = ST_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bits_q      <= '0;
            fill_q      <= '0;
            last_seen_q <= 1'b0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            for (int i = 0; i < NUM_SYMBOLS; i++) begin
                enc_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bits_q      <= bits_d;
            fill_q      <= fill_d;
            last_seen_q <= last_seen_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            enc_q       <= enc_d;
            len_q       <= len_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sym_out   = sym_out_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule
